// File: rtl/pulse_decoder_if.sv
// Parallel side of the pulse-width byte link receiver: serial line and frame
// length in, decoded bytes plus one-cycle strobes out.
interface pulse_decoder_if;
   logic       Din;
   logic [3:0] N;
   logic [7:0] Dout;
   logic [3:0] Addr;
   logic       Dvalid;
   logic       Done;
   logic       Err;

   modport master (
      output Din,
      output N,
      input  Dout,
      input  Addr,
      input  Dvalid,
      input  Done,
      input  Err
   );

   modport slave (
      input  Din,
      input  N,
      output Dout,
      output Addr,
      output Dvalid,
      output Done,
      output Err
   );
endinterface

// File: rtl/pulse_decoder.sv
// Pulse-width frame receiver: classifies synchronized high pulses as short/long,
// assembles LSB-first bytes and strobes Dvalid/Done/Err from registered outputs.
module pulse_decoder #(
   parameter int unsigned SHORT_MIN = 3,
   parameter int unsigned SHORT_MAX = 7,
   parameter int unsigned LONG_MIN  = 12,
   parameter int unsigned LONG_MAX  = 18,
   parameter int unsigned GAP_MAX   = 8
) (
   input  logic            Clk,
   input  logic            Rst,
   pulse_decoder_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE,
      PRE,
      DATA,
      STOP
   } state_t;

   typedef enum logic [1:0] {
      PULSE_NONE,
      PULSE_SHORT,
      PULSE_LONG,
      PULSE_INVALID
   } pulse_t;

   localparam logic [4:0] CNT_MAX  = 5'd31;
   localparam logic [4:0] SHORT_LO = 5'(SHORT_MIN);
   localparam logic [4:0] SHORT_HI = 5'(SHORT_MAX);
   localparam logic [4:0] LONG_LO  = 5'(LONG_MIN);
   localparam logic [4:0] LONG_HI  = 5'(LONG_MAX);
   localparam logic [4:0] GAP_LIM  = 5'(GAP_MAX + 1);

   logic [1:0] sync_q, sync_d;
   logic       s_d_q, s_d_d;
   logic [4:0] hi_cnt_q, hi_cnt_d;
   logic [4:0] lo_cnt_q, lo_cnt_d;

   state_t     state_q, state_d;
   logic [3:0] n_q, n_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [3:0] byte_cnt_q, byte_cnt_d;
   logic [7:0] sr_q, sr_d;

   logic [7:0] dout_q, dout_d;
   logic [3:0] addr_q, addr_d;
   logic       dvalid_q, dvalid_d;
   logic       done_q, done_d;
   logic       err_q, err_d;

   logic       s;
   logic       rise;
   logic       fall;
   logic       timeout;
   pulse_t     pulse;
   logic       bit_in;
   logic [7:0] shifted;

   // Both counters include the edge cycle itself, so hi_cnt equals the pulse width at the fall.
   always_comb begin
      sync_d   = {sync_q[0], bus.Din};
      s        = sync_q[1];
      s_d_d    = s;
      rise     = s & ~s_d_q;
      fall     = ~s & s_d_q;

      hi_cnt_d = hi_cnt_q;
      if (rise) begin
         hi_cnt_d = 5'd1;
      end else if (s && (hi_cnt_q != CNT_MAX)) begin
         hi_cnt_d = hi_cnt_q + 5'd1;
      end

      lo_cnt_d = lo_cnt_q;
      if (fall) begin
         lo_cnt_d = 5'd1;
      end else if (!s && (lo_cnt_q != CNT_MAX)) begin
         lo_cnt_d = lo_cnt_q + 5'd1;
      end
   end

   always_comb begin
      pulse = PULSE_NONE;
      if (fall) begin
         if ((hi_cnt_q >= SHORT_LO) && (hi_cnt_q <= SHORT_HI)) begin
            pulse = PULSE_SHORT;
         end else if ((hi_cnt_q >= LONG_LO) && (hi_cnt_q <= LONG_HI)) begin
            pulse = PULSE_LONG;
         end else begin
            pulse = PULSE_INVALID;
         end
      end
   end

   // On a fall cycle lo_cnt still holds the previous gap, so only a steady low can time out.
   assign timeout = (state_q != IDLE) && !s && !fall && (lo_cnt_q >= GAP_LIM);
   assign bit_in  = (pulse == PULSE_LONG);
   assign shifted = {bit_in, sr_q[7:1]};

   always_comb begin
      state_d    = state_q;
      n_d        = n_q;
      bit_cnt_d  = bit_cnt_q;
      byte_cnt_d = byte_cnt_q;
      sr_d       = sr_q;
      dout_d     = dout_q;
      addr_d     = addr_q;
      dvalid_d   = 1'b0;
      done_d     = 1'b0;
      err_d      = 1'b0;

      case (state_q)
         IDLE: begin
            if (pulse == PULSE_SHORT) begin
               state_d = PRE;
            end
         end

         PRE: begin
            case (pulse)
               PULSE_LONG: begin
                  state_d    = DATA;
                  n_d        = bus.N;
                  bit_cnt_d  = 3'd0;
                  byte_cnt_d = 4'd0;
               end
               PULSE_INVALID: begin
                  state_d = IDLE;
                  err_d   = 1'b1;
               end
               default: begin
               end
            endcase
         end

         DATA: begin
            case (pulse)
               PULSE_SHORT, PULSE_LONG: begin
                  sr_d      = shifted;
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     dout_d   = shifted;
                     addr_d   = byte_cnt_q;
                     dvalid_d = 1'b1;
                     if (byte_cnt_q == n_q) begin
                        state_d = STOP;
                     end else begin
                        byte_cnt_d = byte_cnt_q + 4'd1;
                     end
                  end
               end
               PULSE_INVALID: begin
                  state_d = IDLE;
                  err_d   = 1'b1;
               end
               default: begin
               end
            endcase
         end

         STOP: begin
            case (pulse)
               PULSE_SHORT: begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
               PULSE_LONG, PULSE_INVALID: begin
                  state_d = IDLE;
                  err_d   = 1'b1;
               end
               default: begin
               end
            endcase
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      if (timeout) begin
         state_d = IDLE;
         err_d   = 1'b1;
      end
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         sync_q   <= 2'b00;
         s_d_q    <= 1'b0;
         hi_cnt_q <= 5'd0;
         lo_cnt_q <= 5'd0;
      end else begin
         sync_q   <= sync_d;
         s_d_q    <= s_d_d;
         hi_cnt_q <= hi_cnt_d;
         lo_cnt_q <= lo_cnt_d;
      end
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q    <= IDLE;
         n_q        <= 4'd0;
         bit_cnt_q  <= 3'd0;
         byte_cnt_q <= 4'd0;
         sr_q       <= 8'd0;
         dout_q     <= 8'd0;
         addr_q     <= 4'd0;
         dvalid_q   <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         n_q        <= n_d;
         bit_cnt_q  <= bit_cnt_d;
         byte_cnt_q <= byte_cnt_d;
         sr_q       <= sr_d;
         dout_q     <= dout_d;
         addr_q     <= addr_d;
         dvalid_q   <= dvalid_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign bus.Dout   = dout_q;
   assign bus.Addr   = addr_q;
   assign bus.Dvalid = dvalid_q;
   assign bus.Done   = done_q;
   assign bus.Err    = err_q;

endmodule

// File: tb/tb_pulse_decoder.sv
// Randomized frame bench for pulse_decoder: frames are built from byte lists and
// the expected strobes (kind, data, index, cycle) are queued for a monitor.
module tb_pulse_decoder;

   localparam int GAP_MAX = 8;

   localparam int F_NONE    = 0;
   localparam int F_BADW    = 1;
   localparam int F_GAP     = 2;
   localparam int F_BADSTOP = 3;
   localparam int F_RESET   = 4;

   typedef enum int {EV_VALID, EV_DONE, EV_ERR} ev_t;

   typedef struct {
      ev_t        kind;
      logic [7:0] data;
      logic [3:0] addr;
      longint     cyc;
   } exp_t;

   logic Clk = 1'b0;
   logic Rst;
   longint cyc = 0;

   pulse_decoder_if bus();

   pulse_decoder dut (
      .Clk (Clk),
      .Rst (Rst),
      .bus (bus)
   );

   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   exp_t       sb_q[$];
   int         checks = 0;
   int         errors = 0;
   logic [7:0] held_dout = 8'd0;
   logic [3:0] held_addr = 4'd0;
   logic [7:0] frame_bytes [16];
   int         wmode = 0;
   int         bad_widths [6] = '{1, 2, 8, 11, 19, 40};

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, actual, expected, cyc);
      end
   endtask

   task automatic expect_event(input ev_t kind, input logic [7:0] d, input logic [3:0] a, input longint c);
      exp_t e;
      e.kind = kind;
      e.data = d;
      e.addr = a;
      e.cyc  = c;
      sb_q.push_back(e);
   endtask

   function automatic int short_w();
      case (wmode)
         0:       return 5;
         1:       return int'($urandom_range(4, 6));
         default: return ($urandom_range(0, 1) != 0) ? 7 : 3;
      endcase
   endfunction

   function automatic int long_w();
      case (wmode)
         0:       return 15;
         1:       return int'($urandom_range(14, 16));
         default: return ($urandom_range(0, 1) != 0) ? 18 : 12;
      endcase
   endfunction

   function automatic int gap_w();
      case (wmode)
         0:       return 5;
         1:       return int'($urandom_range(1, GAP_MAX));
         default: return ($urandom_range(0, 1) != 0) ? GAP_MAX : 1;
      endcase
   endfunction

   // Caller sits on a falling clock edge; the line drops at the returned cycle stamp.
   task automatic drive_high(input int hi, output longint fall_cyc);
      bus.Din = 1'b1;
      repeat (hi) @(negedge Clk);
      bus.Din = 1'b0;
      fall_cyc = cyc;
   endtask

   task automatic idle_low(input int lo);
      repeat (lo) @(negedge Clk);
   endtask

   task automatic applyStimulus(input int n, input int fault, input int fpos, input int fwidth,
                                input bit stray, input int tail);
      longint c;
      logic   b;
      int     w;
      bus.N = 4'(n);
      if (stray) begin
         drive_high(long_w(), c);  idle_low(gap_w() + 10);
         drive_high(long_w(), c);  idle_low(gap_w());
         drive_high(short_w(), c); idle_low(gap_w());
      end
      drive_high(short_w(), c); idle_low(gap_w());
      drive_high(long_w(), c);  idle_low(gap_w());
      for (int i = 0; i < 8 * (n + 1); i++) begin
         b = frame_bytes[i / 8][i % 8];
         w = b ? long_w() : short_w();
         if (fault == F_RESET && i == fpos) begin
            bus.Din = 1'b1;
            idle_low(2);
            Rst = 1'b0;
            sb_q.delete();
            held_dout = 8'd0;
            held_addr = 4'd0;
            #1;
            checkOutput("Dout in reset", bus.Dout, 8'd0);
            checkOutput("Addr in reset", bus.Addr, 4'd0);
            checkOutput("Dvalid in reset", bus.Dvalid, 1'b0);
            checkOutput("Done in reset", bus.Done, 1'b0);
            checkOutput("Err in reset", bus.Err, 1'b0);
            bus.Din = 1'b0;
            @(negedge Clk);
            idle_low(3);
            Rst = 1'b1;
            idle_low(5);
            return;
         end
         if (fault == F_BADW && i == fpos) begin
            drive_high(fwidth, c);
            expect_event(EV_ERR, 8'd0, 4'd0, c + 3);
            idle_low(25);
            return;
         end
         drive_high(w, c);
         // The frame length was latched at the preamble; later changes must be ignored.
         if (i == 0) bus.N = 4'($urandom);
         if (i % 8 == 7) expect_event(EV_VALID, frame_bytes[i / 8], 4'(i / 8), c + 3);
         if (fault == F_GAP && i == fpos) begin
            expect_event(EV_ERR, 8'd0, 4'd0, c + GAP_MAX + 4);
            idle_low(25);
            return;
         end
         idle_low(gap_w());
      end
      if (fault == F_BADSTOP) begin
         drive_high(long_w(), c);
         expect_event(EV_ERR, 8'd0, 4'd0, c + 3);
         idle_low(25);
      end else begin
         drive_high(short_w(), c);
         expect_event(EV_DONE, 8'd0, 4'd0, c + 3);
         idle_low(tail);
      end
   endtask

   always @(negedge Clk) begin : monitor
      exp_t e;
      int   nstrobe;
      ev_t  got;
      if (Rst === 1'b1) begin
         while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("[TB] FAIL missing strobe: kind %0d due cycle %0d, not observed by cycle %0d",
                     sb_q[0].kind, sb_q[0].cyc, cyc);
            void'(sb_q.pop_front());
         end
         nstrobe = int'(bus.Dvalid) + int'(bus.Done) + int'(bus.Err);
         if (nstrobe > 1) begin
            checkOutput("strobe exclusivity", 64'(nstrobe), 64'd1);
         end
         if (nstrobe != 0) begin
            got = bus.Dvalid ? EV_VALID : (bus.Done ? EV_DONE : EV_ERR);
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected strobe: kind %0d at cycle %0d, none expected", got, cyc);
            end else begin
               e = sb_q.pop_front();
               checkOutput("strobe kind", got, e.kind);
               checkOutput("strobe cycle", cyc, e.cyc);
               if (e.kind == EV_VALID) begin
                  held_dout = e.data;
                  held_addr = e.addr;
               end
            end
         end
         checkOutput("Dout", bus.Dout, held_dout);
         checkOutput("Addr", bus.Addr, held_addr);
      end
   end

   initial begin : watchdog
      #900000;
      errors++;
      $display("[TB] FAIL watchdog: simulation still running at cycle %0d, expected to finish", cyc);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : stimulus
      int n;
      int f;
      Rst     = 1'b0;
      bus.Din = 1'b0;
      bus.N   = 4'd0;
      repeat (3) @(negedge Clk);
      checkOutput("reset Dout", bus.Dout, 8'd0);
      checkOutput("reset Addr", bus.Addr, 4'd0);
      checkOutput("reset Dvalid", bus.Dvalid, 1'b0);
      checkOutput("reset Done", bus.Done, 1'b0);
      checkOutput("reset Err", bus.Err, 1'b0);
      Rst = 1'b1;
      idle_low(3);

      $display("[TB] directed frames");
      wmode = 0;
      frame_bytes[0] = 8'hA5;
      applyStimulus(0, F_NONE, 0, 0, 1'b0, 10);
      frame_bytes[0] = 8'h01; frame_bytes[1] = 8'h80; frame_bytes[2] = 8'hFF;
      applyStimulus(2, F_NONE, 0, 0, 1'b0, 10);
      frame_bytes[0] = 8'h5A; frame_bytes[1] = 8'hC3;
      applyStimulus(1, F_BADW, 11, 10, 1'b0, 0);
      applyStimulus(1, F_NONE, 0, 0, 1'b0, 10);
      frame_bytes[0] = 8'h96;
      applyStimulus(0, F_GAP, 3, 0, 1'b0, 0);
      frame_bytes[0] = 8'h3C;
      applyStimulus(0, F_NONE, 0, 0, 1'b1, 10);
      for (int k = 0; k < 4; k++) frame_bytes[k] = 8'(8'h11 * (k + 3));
      applyStimulus(3, F_RESET, 12, 0, 1'b0, 0);
      applyStimulus(3, F_NONE, 0, 0, 1'b0, 10);
      applyStimulus(0, F_BADSTOP, 0, 0, 1'b0, 0);

      $display("[TB] boundary widths, long frame, back-to-back frames");
      wmode = 2;
      for (int k = 0; k < 16; k++) frame_bytes[k] = 8'($urandom);
      applyStimulus(15, F_NONE, 0, 0, 1'b0, 1);
      applyStimulus(1, F_NONE, 0, 0, 1'b0, 1);
      applyStimulus(0, F_NONE, 0, 0, 1'b0, 8);
      for (int k = 0; k < 6; k++) begin
         frame_bytes[0] = 8'($urandom);
         applyStimulus(0, F_BADW, int'($urandom_range(0, 7)), bad_widths[k], 1'b0, 0);
      end

      $display("[TB] randomized frames");
      wmode = 1;
      for (int t = 0; t < 40; t++) begin
         n = int'($urandom_range(0, 5));
         for (int k = 0; k < 16; k++) frame_bytes[k] = 8'($urandom);
         case ($urandom_range(0, 9))
            6:       f = F_BADW;
            7:       f = F_GAP;
            8:       f = F_BADSTOP;
            9:       f = F_RESET;
            default: f = F_NONE;
         endcase
         applyStimulus(n, f, int'($urandom_range(0, 8 * (n + 1) - 1)),
                       bad_widths[$urandom_range(0, 5)], 1'($urandom_range(0, 1)),
                       int'($urandom_range(1, 12)));
      end

      for (int k = 0; k < 100 && sb_q.size() != 0; k++) @(negedge Clk);
      idle_low(5);
      checkOutput("scoreboard drained", 64'(sb_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pulse_decoder.md
# pulse_decoder

Serial pulse-width frame receiver: samples a single-wire line carrying frames of N+1 bytes, recovers each byte LSB-first, and presents it on a parallel output with a one-cycle valid strobe. It is the receiving end of the team's pulse-width byte link and drives downstream byte buffers/consumers. Malformed pulses and line timeouts abort the frame with an error strobe.

## Interface
- SHORT_MIN, 3: minimum high width (cycles) of a short pulse
- SHORT_MAX, 7: maximum high width of a short pulse
- LONG_MIN, 12: minimum high width of a long pulse
- LONG_MAX, 18: maximum high width of a long pulse
- GAP_MAX, 8: maximum low gap (cycles) between pulses inside a frame
- Clk  input  1  clock, all logic on rising edge
- Rst  input  1  reset, asynchronous, active-low
- Din  input  1  serial line, asynchronous to Clk, idles low
- N  input  4  frame length minus one (bytes = N+1), latched at preamble completion
- Dout  output  8  received byte, held until next byte
- Addr  output  4  index (0..N) of byte on Dout
- Dvalid  output  1  one-cycle strobe, Dout/Addr valid
- Done  output  1  one-cycle strobe, complete frame received
- Err  output  1  one-cycle strobe, frame aborted

## Operation
- Din passes a 2-flop synchronizer; s = synchronized line, s_d = s delayed one cycle. Rise: s=1,s_d=0; fall: s=0,s_d=1.
- hi_cnt (5 bits, saturating at 31): cleared on rise, increments each cycle s=1. lo_cnt (5 bits, saturating): cleared on fall, increments each cycle s=0.
- At each fall, the pulse is classified by hi_cnt: SHORT if SHORT_MIN..SHORT_MAX, LONG if LONG_MIN..LONG_MAX, else INVALID.
- Frame: preamble (SHORT then LONG), 8*(N+1) data pulses (SHORT=0, LONG=1; byte 0 first, bit 0 first), stop pulse (SHORT), then idle low.
- States: IDLE, PRE, DATA, STOP.
- IDLE: SHORT → PRE; LONG/INVALID ignored, no Err.
- PRE: LONG → DATA, latch N into N_reg, clear bit_cnt (3b), byte_cnt (4b); SHORT → stay PRE (new preamble start); INVALID → IDLE, Err.
- DATA: SHORT/LONG shift bit in: sr <= {bit, sr[7:1]}, bit_cnt++. On 8th bit (bit_cnt==7): Dout <= completed byte, Addr <= byte_cnt, Dvalid; if byte_cnt==N_reg → STOP else byte_cnt++. INVALID → IDLE, Err.
- STOP: SHORT → IDLE, Done; LONG/INVALID → IDLE, Err. Bytes already delivered are not retracted.
- Timeout: in PRE, DATA, STOP, lo_cnt reaching GAP_MAX+1 while s=0 → IDLE, Err. Not applied in IDLE.
- N changes after latch have no effect until next preamble. N=0 gives one-byte frames; N=15 gives 16 bytes (byte_cnt never wraps).
- Rst low at any time: all state cleared, to IDLE; partial frame discarded, no Done/Err.

## Timing
- Reset values: Dout=0, Addr=0, Dvalid=0, Done=0, Err=0; state IDLE, all counters 0, synchronizer flops 0.
- All outputs registered. Dvalid/Done/Err assert the cycle after the fall is detected, i.e. 3 Clk edges after the first edge sampling Din low; width exactly one cycle.
- Timeout Err asserts the cycle after lo_cnt reaches GAP_MAX+1 (GAP_MAX+4 edges after Din low is first sampled).
- Dvalid, Done, Err mutually exclusive in any cycle. Dout/Addr change only with Dvalid.
- Minimum symbol: SHORT_MIN high + 1 low; decoder accepts back-to-back frames with no idle beyond one low cycle after stop.
- Pulse widths measured in synchronized domain; jitter ±1 cycle on nominal 5/15-cycle pulses stays within bounds.

## Test plan
- N=0, send preamble (5h/5l, 15h/5l), byte 0xA5 (5-high=0, 15-high=1, 5-low gaps), stop 5h → one Dvalid with Dout=0xA5, Addr=0; Done 3 cycles after stop fall; Err never.
- N=2, bytes 0x01,0x80,0xFF → Dvalid ×3 with Addr 0,1,2 and matching Dout; single Done.
- N=1, 10-cycle high pulse in byte 1 → Err after that fall, Dvalid only for byte 0, no Done; next valid frame decodes normally.
- N=0, 12-cycle low gap after bit 3 → Err at GAP_MAX+4 edges after gap start, state IDLE.
- Stray LONG pulses then SHORT,SHORT,LONG preamble, N=0, byte 0x3C → no Err from stray pulses, Dout=0x3C, Done.
- Rst pulsed low mid-byte of N=3 frame → all outputs 0 immediately, no Done/Err; subsequent frame decodes correctly.
